spi_tuning_rx: RTL and testbench
================================

Name: spi_tuning_rx

Overview:
- SPI slave (mode 0) that deserialises tuning-update frames from the host MCU.
- Produces the tuning-update interface consumed by the oscillator block: a one-cycle update flag, a 32-bit tuning code and an 8-bit voice index.
- Sits between the board SPI pins and the phase-accumulator engine, in the single i_clk domain.
- Also echoes the last committed voice index on MISO so the host can confirm delivery.

Parameters:
- FRAME_BITS, 40, total bits per frame: 8 voice-index bits then 32 tuning-code bits, MSB first. Fixed layout; only 40 is supported.
- SYNC_STAGES, 2, synchroniser depth for SCLK, CS_n and MOSI; minimum 2.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_spi_sclk  in  1  SPI clock from host, asynchronous to i_clk.
- i_spi_cs_n  in  1  SPI chip select, active low, asynchronous.
- i_spi_mosi  in  1  SPI data in, asynchronous.
- o_spi_miso  out  1  SPI data out.
- o_SPI_flag  out  1  one-cycle pulse: new update valid.
- o_SPI_tuning_code  out  32  committed tuning code (delta phase).
- o_SPI_voice_index  out  8  committed voice index.
- o_frame_error  out  1  one-cycle pulse: malformed frame discarded.
- o_frame_count  out  16  count of committed frames, wraps.

Behaviour:
- Reset (i_reset_n low, asynchronous): all outputs 0, shift register 0, bit counter 0, synchronisers to idle values (sclk 0, cs_n 1, mosi 0), state IDLE.
- Synchronisation:
  - All three SPI inputs pass SYNC_STAGES flops, plus one history flop on SCLK and CS_n for edge detection.
  - Requirement on the host: SCLK ≤ i_clk/8, each SCLK phase ≥ 4 i_clk cycles.
- FSM states: IDLE, SHIFT, COMMIT, ERROR.
  - IDLE -> SHIFT on synchronised CS_n falling edge. Bit counter cleared; 40-bit shift register cleared.
  - SHIFT, on each synchronised SCLK rising edge: shift register <= {sr[38:0], mosi_sync}; counter increments, saturating at 41.
  - SHIFT, on synchronised CS_n rising edge: go to COMMIT if counter == 40, else go to ERROR.
  - COMMIT, one cycle:
    - o_SPI_voice_index <= sr[39:32]; o_SPI_tuning_code <= sr[31:0].
    - o_SPI_flag <= 1 for exactly one cycle.
    - o_frame_count += 1, wrapping 0xFFFF -> 0.
    - -> IDLE.
  - ERROR, one cycle: o_frame_error pulses for one cycle; data outputs unchanged; no flag -> IDLE.
- Latency: o_SPI_flag is high on the i_clk cycle starting SYNC_STAGES+2 rising edges after i_spi_cs_n rises (4 with default).
- Data outputs hold their value until the next COMMIT. They change only in the same cycle the flag rises.
- SCLK edges while CS_n is high are ignored.
- A CS_n falling edge during COMMIT or ERROR is not lost: it is handled in the following IDLE cycle, because the edge flag is held until consumed.
- SCLK rising edge and CS_n rising edge detected in the same cycle: the shift is applied first, then the counter is checked.
- MISO:
  - On each synchronised SCLK falling edge during SHIFT, drive the bits of the last committed voice index MSB first for the first 8 bits, then 0.
  - Bit 7 is presented on CS_n fall.
  - o_spi_miso is 0 when CS_n is high.
- No back-pressure. The consumer must accept the flag pulse. Frames arriving faster than the consumer's service rate overwrite the held data; the flag re-pulses per frame.
- Reset mid-frame: frame discarded, no flag, no error pulse.

Test Plan:
- Frame voice=0x05, code=0x0123_4567 at SCLK=i_clk/8 -> o_SPI_flag one cycle, 4 cycles after CS_n rise; o_SPI_voice_index=0x05; o_SPI_tuning_code=0x01234567; o_frame_count=1.
- 39-bit frame, then 41-bit frame -> two o_frame_error pulses, no flag; data outputs keep prior 0x05/0x01234567; frame_count unchanged.
- Two back-to-back frames (0x10/0xFFFFFFFF, then 0x7F/0x00000001) with one SCLK period of CS_n high between them -> two flags; final outputs 0x7F/0x00000001; frame_count=2.
- Second frame after a committed voice 0xA5 -> MISO bits on the first 8 SCLK rising edges read 1,0,1,0,0,1,0,1, then 0.
- i_reset_n asserted after 20 bits, released, then a full frame 0x03/0x00ABCDEF -> no flag or error for the aborted frame; one flag with 0x03/0x00ABCDEF; frame_count=1.
- Preload frame_count=0xFFFF via 65535 short frames (or a force) -> next valid frame wraps count to 0x0000 with the flag asserted.

Source files
------------

// File: rtl/spi_tuning_rx.sv
// SPI mode-0 slave that receives 40-bit tuning-update frames (voice index + tuning code)
// and presents them to the oscillator block as a one-cycle update pulse with held data.
module spi_tuning_rx #(
  parameter int unsigned FRAME_BITS  = 40,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_spi_sclk,
  input  logic        i_spi_cs_n,
  input  logic        i_spi_mosi,
  output logic        o_spi_miso,
  output logic        o_SPI_flag,
  output logic [31:0] o_SPI_tuning_code,
  output logic [7:0]  o_SPI_voice_index,
  output logic        o_frame_error,
  output logic [15:0] o_frame_count
);

  localparam int unsigned CntW = $clog2(FRAME_BITS + 2);
  localparam logic [CntW-1:0] CntFull = CntW'(FRAME_BITS);
  localparam logic [CntW-1:0] CntSat  = CntW'(FRAME_BITS + 1);
  localparam logic [CntW-1:0] CntEcho = CntW'(8);

  typedef enum logic [1:0] {StIdle, StShift, StCommit, StError} state_e;

  // Input synchronisers plus one history flop for edge detection
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_hist_q;
  logic                   cs_hist_q;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_spi_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_spi_mosi};
      sclk_hist_q <= sclk_s;
      cs_hist_q   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign cs_rise   = cs_s & ~cs_hist_q;
  assign cs_fall   = ~cs_s & cs_hist_q;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic                  fall_pend_q, fall_pend_d;
  logic                  miso_q, miso_d;
  logic                  flag_q, flag_d;
  logic                  err_q, err_d;
  logic [7:0]            voice_q, voice_d;
  logic [31:0]           code_q, code_d;
  logic [15:0]           count_q, count_d;
  logic [2:0]            echo_idx;

  assign echo_idx = 3'd7 - cnt_q[2:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    miso_d      = miso_q;
    voice_d     = voice_q;
    code_d      = code_q;
    count_d     = count_q;
    flag_d      = 1'b0;
    err_d       = 1'b0;
    // A chip-select fall seen outside IDLE is remembered until IDLE can start the frame
    fall_pend_d = fall_pend_q | cs_fall;

    unique case (state_q)
      StIdle: begin
        miso_d = 1'b0;
        if (cs_fall || fall_pend_q) begin
          state_d     = StShift;
          cnt_d       = '0;
          sr_d        = '0;
          fall_pend_d = 1'b0;
          miso_d      = voice_q[7];
        end
      end
      StShift: begin
        if (sclk_rise) begin
          sr_d = {sr_q[FRAME_BITS-2:0], mosi_s};
          if (cnt_q != CntSat) begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        if (sclk_fall) begin
          miso_d = (cnt_q < CntEcho) ? voice_q[echo_idx] : 1'b0;
        end
        // Uses cnt_d so a final clock edge coincident with CS rise is counted
        if (cs_rise) begin
          state_d = (cnt_d == CntFull) ? StCommit : StError;
        end
      end
      StCommit: begin
        flag_d  = 1'b1;
        voice_d = sr_q[FRAME_BITS-1 -: 8];
        code_d  = sr_q[31:0];
        count_d = count_q + 16'd1;
        miso_d  = 1'b0;
        state_d = StIdle;
      end
      StError: begin
        err_d   = 1'b1;
        miso_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sr_q        <= '0;
      fall_pend_q <= 1'b0;
      miso_q      <= 1'b0;
      flag_q      <= 1'b0;
      err_q       <= 1'b0;
      voice_q     <= '0;
      code_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      fall_pend_q <= fall_pend_d;
      miso_q      <= miso_d;
      flag_q      <= flag_d;
      err_q       <= err_d;
      voice_q     <= voice_d;
      code_q      <= code_d;
      count_q     <= count_d;
    end
  end

  wire frame_count_unused = 1'b0;

  logic [15:0] frame_count_q;
  assign frame_count_q = count_q;

  assign o_spi_miso        = miso_q & ~i_spi_cs_n;
  assign o_SPI_flag        = flag_q;
  assign o_SPI_tuning_code = code_q;
  assign o_SPI_voice_index = voice_q;
  assign o_frame_error     = err_q;
  assign o_frame_count     = frame_count_q;

endmodule

// File: tb/tb_spi_tuning_rx.sv
// Self-checking bench for spi_tuning_rx: table-driven frames, corner-case sequences and
// randomized frames checked against a frame-level model of the receiver.
module tb_spi_tuning_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic        flag;
  logic [31:0] code;
  logic [7:0]  voice;
  logic        ferr;
  logic [15:0] fcount;

  always #5 clk = ~clk;

  spi_tuning_rx dut (
    .i_clk             (clk),
    .i_reset_n         (rst_n),
    .i_spi_sclk        (sclk),
    .i_spi_cs_n        (cs_n),
    .i_spi_mosi        (mosi),
    .o_spi_miso        (miso),
    .o_SPI_flag        (flag),
    .o_SPI_tuning_code (code),
    .o_SPI_voice_index (voice),
    .o_frame_error     (ferr),
    .o_frame_count     (fcount)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pulse counting, flag latency since CS rise, and data-hold watch
  int flag_total = 0;
  int err_total = 0;
  int since_rise = 0;
  int last_lat = 0;
  int hold_viol = 0;
  logic [7:0]  prev_v = '0;
  logic [31:0] prev_c = '0;

  always @(negedge clk) begin
    if (cs_n) since_rise = since_rise + 1;
    else since_rise = 0;
    if (flag) begin
      flag_total = flag_total + 1;
      last_lat = since_rise;
    end
    if (ferr) err_total = err_total + 1;
    if (rst_n && !flag && (voice != prev_v || code != prev_c)) hold_viol = hold_viol + 1;
    prev_v = voice;
    prev_c = code;
  end

  // Frame-level reference model
  logic [7:0]  m_voice = '0;
  logic [31:0] m_code = '0;
  logic [15:0] m_count = '0;
  int exp_flags_acc = 0;
  int exp_errs_acc = 0;
  int flag_base = 0;
  int err_base = 0;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [63:0] data, input int nbits);
    int   p;
    logic exp_bit;
    for (int i = 0; i < nbits; i++) begin
      p = nbits - 1 - i;
      mosi = (p < 64) ? data[p] : 1'b0;
      cyc(4);
      exp_bit = (i < 8) ? m_voice[7-i] : 1'b0;
      chk("miso_bit", 64'(miso), 64'(exp_bit));
      sclk = 1'b1;
      cyc(4);
      sclk = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag, input logic lat_check);
    chk({tag, "_flags"}, 64'(flag_total - flag_base), 64'(exp_flags_acc));
    chk({tag, "_errors"}, 64'(err_total - err_base), 64'(exp_errs_acc));
    if (lat_check) chk({tag, "_latency"}, 64'(last_lat), 64'd4);
    chk({tag, "_voice"}, 64'(voice), 64'(m_voice));
    chk({tag, "_code"}, 64'(code), 64'(m_code));
    chk({tag, "_count"}, 64'(fcount), 64'(m_count));
    chk({tag, "_miso_idle"}, 64'(miso), 64'd0);
    flag_base = flag_total;
    err_base = err_total;
    exp_flags_acc = 0;
    exp_errs_acc = 0;
  endtask

  // hi = CS high cycles after the frame; short gaps defer checking to the next frame
  task automatic run_frame(input logic [63:0] data, input int nbits, input int hi,
                           input logic exp_flag, input string tag);
    cs_n = 1'b0;
    cyc(4);
    send_bits(data, nbits);
    cyc(4);
    cs_n = 1'b1;
    if (exp_flag) begin
      m_voice = data[39:32];
      m_code  = data[31:0];
      m_count = m_count + 16'd1;
      exp_flags_acc++;
    end else begin
      exp_errs_acc++;
    end
    cyc(hi);
    if (hi >= 8) check_outputs(tag, exp_flag);
  endtask

  typedef struct {
    logic [63:0] data;
    int          nbits;
    int          hi;
    logic        exp_flag;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int          nb;
    int          sel;
    logic [63:0] rd;

    vecs[0] = '{64'h0000_0005_0123_4567, 40, 8, 1'b1};
    vecs[1] = '{64'h0000_0055_5555_5555, 39, 8, 1'b0};
    vecs[2] = '{64'h0000_01AA_55AA_55AA, 41, 8, 1'b0};
    vecs[3] = '{64'h0000_0010_FFFF_FFFF, 40, 8, 1'b1};
    vecs[4] = '{64'h0000_007F_0000_0001, 40, 8, 1'b1};
    vecs[5] = '{64'h0000_00A5_1234_5678, 40, 8, 1'b1};
    vecs[6] = '{64'h0000_003C_DEAD_BEEF, 40, 8, 1'b1};
    vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 104, 8, 1'b0};

    cyc(3);
    chk("reset_voice", 64'(voice), 64'd0);
    chk("reset_code", 64'(code), 64'd0);
    chk("reset_count", 64'(fcount), 64'd0);
    chk("reset_flag", 64'(flag), 64'd0);
    chk("reset_error", 64'(ferr), 64'd0);
    chk("reset_miso", 64'(miso), 64'd0);
    rst_n = 1'b1;
    cyc(5);

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i].data, vecs[i].nbits, vecs[i].hi, vecs[i].exp_flag,
                $sformatf("vec%0d", i));
    end

    // Back-to-back: CS high one SCLK period, then one clock, so CS falls during COMMIT
    run_frame(64'h0000_0010_FFFF_FFFF, 40, 8, 1'b1, "b2b_gap");
    run_frame(64'h0000_007F_0000_0001, 40, 8, 1'b1, "b2b_gap2");
    run_frame(64'h0000_0022_CAFE_F00D, 40, 1, 1'b1, "b2b_fast_a");
    run_frame(64'h0000_0044_0BAD_BEEF, 40, 8, 1'b1, "b2b_fast_b");

    // Reset in the middle of a frame
    cs_n = 1'b0;
    cyc(4);
    send_bits(64'h0000_0099_8765_4321, 20);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    m_voice = '0;
    m_code  = '0;
    m_count = '0;
    cyc(2);
    chk("midreset_voice", 64'(voice), 64'd0);
    chk("midreset_code", 64'(code), 64'd0);
    chk("midreset_count", 64'(fcount), 64'd0);
    chk("midreset_miso", 64'(miso), 64'd0);
    cs_n = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(10);
    check_outputs("aborted", 1'b0);
    run_frame(64'h0000_0003_00AB_CDEF, 40, 8, 1'b1, "post_reset");

    for (int r = 0; r < 10; r++) begin
      sel = int'($urandom_range(0, 5));
      if (sel <= 2) nb = 40;
      else if (sel == 3) nb = 39;
      else if (sel == 4) nb = 41;
      else nb = int'($urandom_range(1, 38));
      rd = {$urandom, $urandom};
      run_frame(rd, nb, 8, nb == 40, $sformatf("rand%0d", r));
    end

    // Frame counter wrap
    force dut.count_q = 16'hFFFF;
    cyc(1);
    release dut.count_q;
    m_count = 16'hFFFF;
    run_frame(64'h0000_0011_2233_4455, 40, 8, 1'b1, "wrap");
    chk("wrap_zero", 64'(fcount), 64'd0);

    chk("data_hold", 64'(hold_viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
